// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a show-ahead byte FIFO.
// The serial line is synchronized, oversampled 16x with a 3-sample majority
// vote at sub-counts 7/8/9, and deframed LSB-first. Sticky frame_err and
// overrun flags report line and FIFO errors until err_clr.
// Optional build macro UART_RX_PARITY_EN: 8E1 framing with a PARITY state
// and a sticky parity_err output; frames with bad parity are discarded.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serial_in,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  frame_err,
  output logic                  overrun,
  input  logic                  err_clr
`ifdef UART_RX_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int DIV   = CLK_HZ / (BAUD * 16);
  localparam int TW    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t state, state_next;

  // Input synchronizer and edge history
  logic s_meta, s_in, s_prev;

  // Oversampling timebase
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    sub_cnt;
  logic          dec;      // sub-count-9 tick: bit decision point
  logic          end_bit;  // sub-count-15 tick: last tick of a bit period
  logic [1:0]    samp;     // samples captured at sub-counts 7 and 8
  logic          majority;

  // Character assembly
  logic [2:0] bit_idx;
  logic [7:0] shift_reg;

  // FSM strobes into the datapath
  logic go_start, shift_en, push_req, frame_set;
`ifdef UART_RX_PARITY_EN
  logic par_set, par_bad;
`endif

  // FIFO storage and control
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  full, do_pop, do_push, drop;

  assign tick     = (tick_cnt == TW'(DIV - 1));
  assign dec      = tick && (sub_cnt == 4'd9);
  assign end_bit  = tick && (sub_cnt == 4'd15);
  // Third sample is the live value on the sub-count-9 tick.
  assign majority = (samp[0] & samp[1]) | (samp[0] & s_in) | (samp[1] & s_in);

  // Two-flop synchronizer plus one stage of history for falling-edge detect
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours, like real hardware.
    if (rst) begin
      s_meta <= 1'b1;
      s_in   <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      s_meta <= serial_in;
      s_in   <= s_meta;
      s_prev <= s_in;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic and datapath strobes
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_next = state;
    go_start   = 1'b0;
    shift_en   = 1'b0;
    push_req   = 1'b0;
    frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_set    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (!s_in && s_prev) begin
          state_next = START;
          go_start   = 1'b1;
        end
      end
      START: begin
        if (dec && majority) state_next = IDLE;   // glitch, not a start bit
        else if (end_bit)    state_next = DATA;
      end
      DATA: begin
        shift_en = dec;
        if (end_bit && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        par_set = dec && ((^shift_reg) ^ majority);
        if (end_bit) state_next = STOP;
      end
`endif
      STOP: begin
        // Decide mid stop bit and return to IDLE at once for fast resync.
        if (dec) begin
          state_next = IDLE;
          if (majority) begin
`ifdef UART_RX_PARITY_EN
            push_req = !par_bad;
`else
            push_req = 1'b1;
`endif
          end else begin
            frame_set = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Tick generator, sub-counter, majority samples and character shifter
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt  <= '0;
      sub_cnt   <= '0;
      samp      <= 2'b11;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      if (go_start) begin
        tick_cnt <= '0;      // align sampling phase to the detected edge
        sub_cnt  <= '0;
      end else if (tick) begin
        tick_cnt <= '0;
        sub_cnt  <= sub_cnt + 4'd1;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
      if (tick && sub_cnt == 4'd7) samp[0] <= s_in;
      if (tick && sub_cnt == 4'd8) samp[1] <= s_in;
      if (shift_en) shift_reg[bit_idx] <= majority;
      if (state == START)              bit_idx <= '0;
      else if (state == DATA && end_bit) bit_idx <= bit_idx + 3'd1;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Per-frame parity verdict, consumed at the stop-bit decision
  always_ff @(posedge clk) begin
    if (rst || go_start) par_bad <= 1'b0;
    else if (par_set)    par_bad <= 1'b1;
  end
`endif

  assign do_pop  = rd_en && rd_valid;
  assign full    = (count == CW'(DEPTH));
  assign do_push = push_req && (!full || do_pop);
  assign drop    = push_req && full && !do_pop;

  // FIFO storage write port
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; contents are only visible through
    // count/rd_valid, so stale entries are never observed.
    if (do_push) mem[wr_ptr] <= shift_reg;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_valid = (count != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

  // Sticky error flags; a new error wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (frame_set)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (drop)         overrun   <= 1'b1;
      else if (err_clr) overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (par_set)      parity_err <= 1'b1;
      else if (err_clr) parity_err <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. A faster core clock (DIV=8, 128 clk
// per bit) keeps the run short while exercising the same timing relations.
// Received bytes are checked against a scoreboard queue filled at send time.
module tb_uart_rx_fifo;

  localparam int BAUD       = 115200;
  localparam int DIV        = 8;
  localparam int CLK_HZ     = BAUD * 16 * DIV;
  localparam int DEPTH_LOG2 = 4;
  localparam int BIT        = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_IDX   = 10;
`else
  localparam int STOP_IDX   = 9;
`endif
  // Cycles from driving the start edge to the push edge: 3 for sync + edge
  // detect, then (16*bit + sub-count + 1) ticks to the stop-bit sub-9 tick.
  localparam int DOFF       = 3 + (16 * STOP_IDX + 10) * DIV;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                serial_in = 1'b1;
  logic                rd_en = 1'b0;
  logic                err_clr = 1'b0;
  logic [7:0]          rd_data;
  logic                rd_valid;
  logic [DEPTH_LOG2:0] count;
  logic                frame_err;
  logic                overrun;
`ifdef UART_RX_PARITY_EN
  logic                parity_err;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [7:0]  exp_q [$];

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr)
`ifdef UART_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_negedge(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  // Drive one frame; the caller aligns to just after a posedge.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic bad_par);
    serial_in = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      wait_cyc(BIT);
    end
`ifdef UART_RX_PARITY_EN
    serial_in = (^d) ^ bad_par;
    wait_cyc(BIT);
`endif
    serial_in = stop_v;
    wait_cyc(BIT);
    serial_in = 1'b1;
  endtask

  task automatic send_ok(input logic [7:0] d);
    @(posedge clk); #1;
    send_frame(d, 1'b1, 1'b0);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    @(negedge clk);
    check({tag, "_valid"}, rd_valid, 1);
    check({tag, "_data"}, rd_data, e);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_err_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int c0;

    // Reset state
    wait_cyc(4);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", rd_valid, 0);
    check("rst_count", count, 0);
    check("rst_data", rd_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    wait_cyc(20);

    // Single byte 0xA5 with push timing relative to the stop-bit decision
    exp_q.push_back(8'hA5);
    @(posedge clk); #1;
    c0 = cyc;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        at_negedge(c0 + DOFF - 1);
        check("a5_valid_before", rd_valid, 0);
        at_negedge(c0 + DOFF);
        check("a5_valid_after", rd_valid, 1);
      end
    join
    @(negedge clk);
    check("a5_count", count, 1);
    check("a5_ferr", frame_err, 0);
    check("a5_ovr", overrun, 0);
    pop_check("a5");
    check("a5_count_end", count, 0);

    // Back-to-back bytes with a single stop bit
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
    @(posedge clk); #1;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    wait_cyc(BIT);
    check("b2b_count", count, 3);
    for (int i = 0; i < 3; i++) pop_check($sformatf("b2b%0d", i));
    check("b2b_count_end", count, 0);

    // Short low glitch on an idle line is rejected as a false start
    serial_in = 1'b0;
    wait_cyc(BIT / 3);
    serial_in = 1'b1;
    wait_cyc(2 * BIT);
    check("glitch_count", count, 0);
    check("glitch_ferr", frame_err, 0);
    check("glitch_ovr", overrun, 0);

    // Framing error: stop bit driven low, byte discarded
    @(posedge clk); #1;
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_cyc(BIT);
    check("ferr_set", frame_err, 1);
    check("ferr_count", count, 0);
    pulse_err_clr();
    check("ferr_clr", frame_err, 0);

    // Overrun: 17 bytes into a 16-entry FIFO with no reads
    for (int i = 1; i <= 17; i++) begin
      if (i <= 16) exp_q.push_back(8'(i));
      send_ok(8'(i));
    end
    wait_cyc(BIT);
    check("ovr_count", count, 16);
    check("ovr_set", overrun, 1);
    for (int i = 0; i < 16; i++) pop_check($sformatf("ovr%0d", i));
    check("ovr_count_end", count, 0);
    pulse_err_clr();
    check("ovr_clr", overrun, 0);

    // Same again, but pop in the 17th byte's push cycle: no overrun
    for (int i = 1; i <= 16; i++) begin
      exp_q.push_back(8'(i));
      send_ok(8'(i));
    end
    exp_q.push_back(8'h11);
    @(posedge clk); #1;
    c0 = cyc;
    fork
      send_frame(8'h11, 1'b1, 1'b0);
      begin
        logic [7:0] e;
        at_negedge(c0 + DOFF - 1);
        e = exp_q.pop_front();
        check("pp_head", rd_data, e);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    wait_cyc(BIT);
    check("pp_ovr", overrun, 0);
    check("pp_count", count, 16);
    for (int i = 0; i < 16; i++) pop_check($sformatf("pp%0d", i));
    check("pp_count_end", count, 0);

    // Reset during the 4th data bit; only the following clean byte lands
    @(posedge clk); #1;
    c0 = cyc;
    fork
      send_frame(8'hF8, 1'b1, 1'b0);
      begin
        at_negedge(c0 + 4 * BIT + BIT / 2);
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
      end
    join
    wait_cyc(BIT);
    check("mrst_count", count, 0);
    check("mrst_ferr", frame_err, 0);
    exp_q.push_back(8'h7E);
    send_ok(8'h7E);
    wait_cyc(BIT);
    check("mrst_count_7e", count, 1);
    pop_check("mrst_7e");
    check("mrst_count_end", count, 0);

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit: sticky parity_err, byte dropped
    @(posedge clk); #1;
    send_frame(8'h7E, 1'b1, 1'b1);
    wait_cyc(BIT);
    check("par_set", parity_err, 1);
    check("par_count", count, 0);
    check("par_ferr", frame_err, 0);
    pulse_err_clr();
    check("par_clr", parity_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
